// File: rtl/volume_envelope_if.sv
// volume_envelope_if: sample stream in, envelope level out for the volume meter detector.
interface volume_envelope_if #(
    parameter int WIDTH = 24
);
    logic             in_valid;
    logic [WIDTH-1:0] l_in_s;
    logic [WIDTH-1:0] r_in_s;
    logic [WIDTH-1:0] l_out;
    logic             level_valid;
    modport master (output in_valid, l_in_s, r_in_s, input l_out, level_valid);
    modport slave  (input in_valid, l_in_s, r_in_s, output l_out, level_valid);
endinterface

// File: rtl/volume_envelope.sv
// volume_envelope: saturated stereo magnitude, per-window peak hold, level publish.
// Optional gradual fall-off of the published level when VOLUME_DECAY_EN is defined.
module volume_envelope #(
    parameter int WIDTH       = 24,
    parameter int WINDOW      = 1024,
    parameter int DECAY_SHIFT = 3
) (
    input logic               clock,
    input logic               resetn,
    volume_envelope_if.slave  bus
);
    localparam int CW = $clog2(WINDOW);
    localparam logic [WIDTH-1:0] MAXP = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MINN = {1'b1, {(WIDTH-1){1'b0}}};
    logic [CW-1:0]    cnt;
    logic             end_cnt, last_q, va;
    logic [WIDTH-1:0] mag_q, win_max, l_abs, r_abs, cand, next_level;
    always_comb begin
        l_abs   = bus.l_in_s == MINN ? MAXP : bus.l_in_s[WIDTH-1] ? -bus.l_in_s : bus.l_in_s;
        r_abs   = bus.r_in_s == MINN ? MAXP : bus.r_in_s[WIDTH-1] ? -bus.r_in_s : bus.r_in_s;
        cand    = mag_q > win_max ? mag_q : win_max;
        end_cnt = cnt == CW'(WINDOW - 1);
    end
`ifdef VOLUME_DECAY_EN
    logic [WIDTH-1:0] dq, dstep, dec;
    // A nonzero level always loses at least 1 so the meter reaches 0.
    always_comb begin
        dq         = bus.l_out >> DECAY_SHIFT;
        dstep      = (dq == '0 && bus.l_out != '0) ? WIDTH'(1) : dq;
        dec        = bus.l_out - dstep;
        next_level = cand > dec ? cand : dec;
    end
`else
    assign next_level = cand;
`endif
    always_ff @(posedge clock) begin
        if (!resetn) begin
            cnt             <= '0;
            last_q          <= 1'b0;
            va              <= 1'b0;
            mag_q           <= '0;
            win_max         <= '0;
            bus.l_out       <= '0;
            bus.level_valid <= 1'b0;
        end else begin
            va              <= bus.in_valid;
            bus.level_valid <= 1'b0;
            if (bus.in_valid) begin
                mag_q  <= l_abs > r_abs ? l_abs : r_abs;
                last_q <= end_cnt;
                cnt    <= end_cnt ? '0 : cnt + 1'b1;
            end
            if (va) begin
                win_max <= last_q ? '0 : cand;
                if (last_q) begin
                    bus.l_out       <= next_level;
                    bus.level_valid <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_volume_envelope.sv
// tb_volume_envelope: directed checks of volume_envelope with WINDOW=8 (decay or plain build).
module tb_volume_envelope;
    logic clock = 1'b0;
    logic resetn = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic [23:0] obs[$];
    volume_envelope_if #(.WIDTH(24)) bus ();
    volume_envelope #(.WIDTH(24), .WINDOW(8), .DECAY_SHIFT(3)) dut (
        .clock(clock), .resetn(resetn), .bus(bus)
    );
    always #5 clock = ~clock;
    always @(posedge clock) begin
        #1;
        if (bus.level_valid) obs.push_back(bus.l_out);
    end
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask
    task automatic send(input int l, input int r);
        @(negedge clock);
        bus.in_valid = 1'b1;
        bus.l_in_s   = 24'(l);
        bus.r_in_s   = 24'(r);
    endtask
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            bus.in_valid = 1'b0;
        end
    endtask
    task automatic do_reset(input int n);
        @(negedge clock);
        resetn = 1'b0;
        bus.in_valid = 1'b0;
        repeat (n) @(negedge clock);
        resetn = 1'b1;
        obs.delete();
    endtask
    task automatic send_win(input int peak);
        for (int i = 0; i < 8; i++) send(i == 2 ? peak : 0, 0);
        idle(3);
    endtask
    task automatic expect_lvl(input string tag, input logic [23:0] e);
        chk({tag, " pulses"}, obs.size(), 1);
        if (obs.size() > 0) chk(tag, obs[0], e);
        obs.delete();
    endtask
    function automatic logic [23:0] mag(input logic [23:0] s);
        if (s == 24'h800000) return 24'h7fffff;
        return s[23] ? 24'(0 - int'(signed'(s))) : s;
    endfunction
    function automatic logic [23:0] model_next(input logic [23:0] prev, input logic [23:0] c);
`ifdef VOLUME_DECAY_EN
        logic [23:0] d;
        d = prev / 8;
        if (d == 0 && prev != 0) d = 1;
        return c > prev - d ? c : prev - d;
`else
        return c;
`endif
    endfunction
    initial begin
        logic [23:0] exp3[3];
        logic [23:0] exp4[6];
        logic [23:0] lvl, peak;
        logic [23:0] ls, rs;
        logic [23:0] expq[$];
        bus.in_valid = 1'b0;
        bus.l_in_s   = '0;
        bus.r_in_s   = '0;
        do_reset(2);
        chk("reset l_out", bus.l_out, 0);
        chk("reset level_valid", bus.level_valid, 0);
        // Test 1: latency and basic magnitude
        for (int i = 0; i < 8; i++) send(1000, -2000);
        @(negedge clock);
        bus.in_valid = 1'b0;
        chk("t1 no early pulse", bus.level_valid, 0);
        @(posedge clock);
        #2;
        chk("t1 pulse at t+1", bus.level_valid, 1);
        chk("t1 l_out", bus.l_out, 2000);
        idle(3);
        chk("t1 single pulse", obs.size(), 1);
        obs.delete();
        // Test 2: most negative sample saturates
        for (int i = 0; i < 8; i++) send(i == 0 ? -8388608 : 0, 0);
        idle(3);
        expect_lvl("t2 saturation", 24'd8388607);
        // Test 3: peak then zero windows
`ifdef VOLUME_DECAY_EN
        exp3 = '{24'd8000, 24'd7000, 24'd6125};
`else
        exp3 = '{24'd8000, 24'd0, 24'd0};
`endif
        do_reset(1);
        send_win(-8000);
        expect_lvl("t3 w0", exp3[0]);
        send_win(0);
        expect_lvl("t3 w1", exp3[1]);
        send_win(0);
        expect_lvl("t3 w2", exp3[2]);
        // Test 4: small level falls to zero and stays
`ifdef VOLUME_DECAY_EN
        exp4 = '{24'd4, 24'd3, 24'd2, 24'd1, 24'd0, 24'd0};
`else
        exp4 = '{24'd0, 24'd0, 24'd0, 24'd0, 24'd0, 24'd0};
`endif
        do_reset(1);
        send_win(5);
        expect_lvl("t4 start", 24'd5);
        for (int w = 0; w < 6; w++) begin
            send_win(0);
            expect_lvl($sformatf("t4 w%0d", w), exp4[w]);
        end
        // Test 5: random gaps, model-predicted levels
        do_reset(1);
        lvl  = '0;
        peak = '0;
        for (int i = 0; i < 64; i++) begin
            ls = 24'($urandom);
            rs = (i % 13 == 5) ? 24'h800000 : 24'($urandom);
            peak = mag(ls) > peak ? mag(ls) : peak;
            peak = mag(rs) > peak ? mag(rs) : peak;
            if (i % 8 == 7) begin
                lvl = model_next(lvl, peak);
                expq.push_back(lvl);
                peak = '0;
            end
            send(int'(ls), int'(rs));
            idle($urandom_range(0, 3));
        end
        idle(3);
        chk("t5 pulses", obs.size(), 8);
        for (int w = 0; w < 8; w++)
            if (w < obs.size()) chk($sformatf("t5 w%0d", w), obs[w], expq[w]);
        obs.delete();
        // Test 6: reset mid-window discards partial window
        do_reset(1);
        for (int i = 0; i < 5; i++) send(i == 1 ? 5000 : 10, 0);
        do_reset(1);
        chk("t6 reset l_out", bus.l_out, 0);
        for (int i = 0; i < 7; i++) send(100, -100);
        idle(3);
        chk("t6 no early pulse", obs.size(), 0);
        send(100, 100);
        idle(3);
        expect_lvl("t6 level", 24'd100);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
